// File: rtl/usr_cmd_seq.sv
// ---------------------------------------------------------------------------
// usr_cmd_seq -- command sequencer for a W-bit universal shift register (USR).
//
// Takes one command at a time over a valid/ready handshake and turns it into
// a cycle-by-cycle USR MODE/DATAIN stream. Rotates are built from the USR's
// own serial shift modes by feeding the bit that falls off one end back in
// on the other end, using the USR DATAOUT (usr_q).
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted (IDLE only)
//   cmd_op     in   0 LOAD, 1 SHR, 2 SHL, 3 ROTR, 4 ROTL, 5 CLEAR, 6-7 illegal
//   cmd_cnt    in   shift/rotate step count (ignored by LOAD/CLEAR)
//   cmd_data   in   parallel load word
//   cmd_fill   in   serial fill bit for SHR/SHL
//   usr_q      in   USR DATAOUT feedback
//   usr_mode   out  USR MODE: 00 hold, 01 shr, 10 shl, 11 load (registered)
//   usr_din    out  USR DATAIN (combinational)
//   busy       out  high while a command is in progress (RUN, DONE)
//   done       out  one-cycle completion pulse
//   err        out  one-cycle pulse with done for an illegal op
// ---------------------------------------------------------------------------
module usr_cmd_seq #(
  parameter int W  = 4,
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [CW-1:0] cmd_cnt,
  input  logic [W-1:0]  cmd_data,
  input  logic          cmd_fill,
  input  logic [W-1:0]  usr_q,
  output logic [1:0]    usr_mode,
  output logic [W-1:0]  usr_din,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_SHR   = 3'd1;
  localparam logic [2:0] OP_SHL   = 3'd2;
  localparam logic [2:0] OP_ROTR  = 3'd3;
  localparam logic [2:0] OP_ROTL  = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd5;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [CW-1:0] remain_q, remain_d;   // doubles as the latched step count
  logic [W-1:0]  data_q, data_d;
  logic          fill_q, fill_d;
  logic [1:0]    mode_q, mode_d;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    remain_d = remain_q;
    data_d   = data_q;
    fill_d   = fill_q;
    mode_d   = mode_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          fill_d = cmd_fill;
          unique case (cmd_op)
            OP_LOAD, OP_CLEAR: begin
              state_d  = S_RUN;
              remain_d = CW'(1);
              mode_d   = MODE_LOAD;
            end
            OP_SHR, OP_ROTR, OP_SHL, OP_ROTL: begin
              remain_d = cmd_cnt;
              // A zero-step shift completes without touching the USR.
              if (cmd_cnt != '0) begin
                state_d = S_RUN;
                mode_d  = (cmd_op == OP_SHR || cmd_op == OP_ROTR) ? MODE_SHR : MODE_SHL;
              end else begin
                state_d = S_DONE;
              end
            end
            default: begin
              // Illegal op: report through err in DONE, USR left alone.
              state_d  = S_DONE;
              remain_d = '0;
            end
          endcase
        end
      end
      S_RUN: begin
        remain_d = remain_q - CW'(1);
        if (remain_q == CW'(1)) begin
          state_d = S_DONE;
          mode_d  = MODE_HOLD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        mode_d  = MODE_HOLD;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of block evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      remain_q <= '0;
      data_q   <= '0;
      fill_q   <= 1'b0;
      mode_q   <= MODE_HOLD;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      remain_q <= remain_d;
      data_q   <= data_d;
      fill_q   <= fill_d;
      mode_q   <= mode_d;
    end
  end

  // Serial input bit for the current step; rotates recycle the bit that is
  // about to leave the register.
  always_comb begin
    usr_din = '0;
    if (state_q == S_RUN) begin
      unique case (op_q)
        OP_LOAD:        usr_din = data_q;
        OP_SHR, OP_SHL: usr_din = {{(W-1){1'b0}}, fill_q};
        OP_ROTR:        usr_din = {{(W-1){1'b0}}, usr_q[0]};
        OP_ROTL:        usr_din = {{(W-1){1'b0}}, usr_q[W-1]};
        default:        usr_din = '0;
      endcase
    end
  end

  assign usr_mode  = mode_q;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_DONE) && (op_q[2:1] == 2'b11);

endmodule
